instruction_sequencer: RTL

Control unit that fetches 16-bit instruction words from program memory, decodes them and drives the combinational ALU's opcode, operand and immediate inputs. It owns the four-entry register file and writes `aluResult` back on the execute cycle. It also handles jumps and halt. It sits between the program ROM and the ALU and forms the control half of the CPU datapath.

---
 rtl/instruction_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute control unit owning a four-entry register file.
// Define SEQUENCER_BRANCH_EN to enable JUMP (8) and JZ (9); otherwise both execute as NOP.
module instruction_sequencer #(
   parameter int OPCODE_WIDTH   = 4,
   parameter int REGISTER_WIDTH = 8,
   parameter int ADDR_WIDTH     = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   output logic [ADDR_WIDTH-1:0]     fetchAddress,
   output logic                      fetchRequest,
   input  logic [15:0]               instructionWord,
   input  logic                      instructionValid,
   output logic [OPCODE_WIDTH-1:0]   opCode,
   output logic [REGISTER_WIDTH-1:0] register1Value,
   output logic [REGISTER_WIDTH-1:0] register2Value,
   output logic [REGISTER_WIDTH-1:0] instructionValue,
   input  logic [REGISTER_WIDTH-1:0] aluResult,
   output logic [ADDR_WIDTH-1:0]     programCounter,
   output logic [REGISTER_WIDTH-1:0] register0Value,
   output logic                      halted
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      EXECUTE,
      HALTED
   } state_t;

   localparam logic [15:0] NOP_WORD    = 16'h7000;
   localparam logic [3:0]  OP_NOP      = 4'd7;
   localparam logic [3:0]  OP_LAST_ALU = 4'd6;
   localparam logic [3:0]  OP_HALT     = 4'd15;
`ifdef SEQUENCER_BRANCH_EN
   localparam logic [3:0]  OP_JUMP     = 4'd8;
   localparam logic [3:0]  OP_JZ       = 4'd9;
`endif

   state_t                    state;
   state_t                    next_state;
   logic [ADDR_WIDTH-1:0]     pc;
   logic [ADDR_WIDTH-1:0]     next_pc;
   logic [15:0]               ir;
   logic [REGISTER_WIDTH-1:0] regs [4];
   logic                      ir_load;
   logic                      reg_write;

   logic [3:0] ir_op;
   logic [1:0] ir_dest;
   logic [1:0] ir_src1;
   logic [1:0] ir_src2;
   logic [7:0] ir_imm;

   assign ir_op   = ir[15:12];
   assign ir_dest = ir[11:10];
   assign ir_src1 = ir[9:8];
   assign ir_src2 = ir[1:0];
   assign ir_imm  = ir[7:0];

   assign fetchAddress     = pc;
   assign programCounter   = pc;
   assign fetchRequest     = (state == FETCH);
   assign halted           = (state == HALTED);
   assign opCode           = (state == EXECUTE) ? OPCODE_WIDTH'(ir_op) : OPCODE_WIDTH'(OP_NOP);
   assign register1Value   = regs[ir_src1];
   assign register2Value   = regs[ir_src2];
   assign instructionValue = REGISTER_WIDTH'(ir_imm);
   assign register0Value   = regs[0];

   always_comb begin
      next_state = state;
      next_pc    = pc;
      ir_load    = 1'b0;
      reg_write  = 1'b0;
      case (state)
         IDLE: next_state = FETCH;
         FETCH: begin
            if (instructionValid) begin
               ir_load    = 1'b1;
               next_state = EXECUTE;
            end
         end
         EXECUTE: begin
            next_state = FETCH;
            next_pc    = pc + ADDR_WIDTH'(1);
            if (ir_op <= OP_LAST_ALU) begin
               reg_write = 1'b1;
            end else if (ir_op == OP_HALT) begin
               next_state = HALTED;
               next_pc    = pc;
            end
`ifdef SEQUENCER_BRANCH_EN
            else if (ir_op == OP_JUMP) begin
               next_pc = ADDR_WIDTH'(ir_imm);
            end else if (ir_op == OP_JZ && register1Value == '0) begin
               next_pc = ADDR_WIDTH'(ir_imm);
            end
`endif
         end
         HALTED: next_state = HALTED;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ALU operands come from the old register values; the write lands on the EXECUTE edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc <= '0;
         ir <= NOP_WORD;
         for (int unsigned i = 0; i < 4; i++) begin
            regs[i] <= '0;
         end
      end else begin
         pc <= next_pc;
         if (ir_load) begin
            ir <= instructionWord;
         end
         if (reg_write) begin
            regs[ir_dest] <= aluResult;
         end
      end
   end

endmodule
